tinydfu_boot_sequencer: RTL and testbench

Sequences the TinyDFU bootloader lifecycle around `usb_dfu_core`.
- Holds the core in reset, then enables the USB host-detect pull-up.
- Runs the autoboot timeout, cancels it on DFU activity or a user button, and handles detach.
- Before requesting the user-image boot, drops the pull-up for a guard interval so the host sees a disconnect.
- Drives the active-low status LEDs from sequencer state.

It sits between `usb_dfu_core` and the board top, replacing ad-hoc counters in each board wrapper.

---
 rtl/tinydfu_pkg.sv | 29 ++
 rtl/tinydfu_boot_sequencer_if.sv | 21 ++
 rtl/tinydfu_led_pattern.sv | 38 +++
 rtl/tinydfu_boot_sequencer.sv | 104 ++++++++++
 tb/tb_tinydfu_boot_sequencer.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/tinydfu_pkg.sv
// Shared types and constants for the TinyDFU boot sequencer.
// The cylon table holds the lit-LED patterns; the outputs invert them because the LEDs are active-low.
package tinydfu_pkg;

    typedef enum logic [2:0] {
        S_HOLD   = 3'd0,
        S_IDLE   = 3'd1,
        S_ACTIVE = 3'd2,
        S_DETACH = 3'd3,
        S_BOOT   = 3'd4
    } boot_state_t;

    typedef enum logic [1:0] {
        LED_OFF   = 2'd0,
        LED_BLINK = 2'd1,
        LED_CYLON = 2'd2
    } led_mode_t;

    localparam logic [7:0] DFU_STATE_IDLE       = 8'h02;
    localparam logic [7:0] DFU_STATE_ACTIVE_MIN = 8'h03;

    // Index 0 is the rightmost entry.
    localparam logic [5:0][2:0] CYLON_PAT = {3'b010, 3'b001, 3'b010, 3'b100, 3'b010, 3'b001};

    function automatic logic [2:0] cylon_led(input logic [2:0] step);
        return ~CYLON_PAT[step];
    endfunction

endpackage

// File: rtl/tinydfu_boot_sequencer_if.sv
// Signals between the boot sequencer, usb_dfu_core and the board top.
interface tinydfu_boot_sequencer_if;
    logic [7:0] dfu_state;
    logic       dfu_detach;
    logic       stay_btn;
    logic       core_reset;
    logic       usb_pull_en;
    logic       boot_now;
    logic       autoboot_armed;
    logic [2:0] led;

    modport master (
        input  dfu_state, dfu_detach, stay_btn,
        output core_reset, usb_pull_en, boot_now, autoboot_armed, led
    );

    modport slave (
        output dfu_state, dfu_detach, stay_btn,
        input  core_reset, usb_pull_en, boot_now, autoboot_armed, led
    );
endinterface

// File: rtl/tinydfu_led_pattern.sv
// Free-running counter driving the idle blink and the cylon step pattern.
// LED output is registered; all timing comes from clk, with no derived clocks.
module tinydfu_led_pattern
    import tinydfu_pkg::*;
#(
    parameter int unsigned BLINK_BIT = 21,
    parameter int unsigned STEP_BIT  = 20
) (
    input  logic      clk,
    input  logic      resetn,
    input  led_mode_t mode,
    output logic [2:0] led
);

    logic [31:0] cnt;
    logic        step_bit_q;
    logic [2:0]  step;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt        <= '0;
            step_bit_q <= 1'b0;
            step       <= '0;
            led        <= 3'b111;
        end else begin
            cnt        <= cnt + 32'd1;
            step_bit_q <= cnt[STEP_BIT];
            if (cnt[STEP_BIT] && !step_bit_q)
                step <= (step == 3'd5) ? 3'd0 : step + 3'd1;
            unique case (mode)
                LED_BLINK: led <= ~{2'b00, cnt[BLINK_BIT]};
                LED_CYLON: led <= cylon_led(step);
                default:   led <= 3'b111;
            endcase
        end
    end

endmodule

// File: rtl/tinydfu_boot_sequencer.sv
// TinyDFU lifecycle: core reset hold, autoboot timeout, detach guard, boot request.
// DFU inputs pass through one register stage; outputs are registered from next-state.
module tinydfu_boot_sequencer
    import tinydfu_pkg::*;
#(
    parameter int unsigned RESET_CYCLES    = 65535,
    parameter int unsigned AUTOBOOT_CYCLES = 60000000,
    parameter int unsigned DETACH_CYCLES   = 12000,
    parameter int unsigned BLINK_BIT       = 21,
    parameter int unsigned STEP_BIT        = 20
) (
    input  logic                        clk,
    input  logic                        resetn,
    tinydfu_boot_sequencer_if.master    bus
);

    boot_state_t state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic        det_q, act_q;
    led_mode_t   mode_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q            <= S_HOLD;
            cnt_q              <= 32'(RESET_CYCLES);
            det_q              <= 1'b0;
            act_q              <= 1'b0;
            bus.core_reset     <= 1'b1;
            bus.usb_pull_en    <= 1'b0;
            bus.boot_now       <= 1'b0;
            bus.autoboot_armed <= 1'b0;
        end else begin
            state_q            <= state_d;
            cnt_q              <= cnt_d;
            det_q              <= bus.dfu_detach;
            act_q              <= (bus.dfu_state >= DFU_STATE_ACTIVE_MIN) || bus.stay_btn;
            bus.core_reset     <= (state_d == S_HOLD) || (state_d == S_BOOT);
            bus.usb_pull_en    <= (state_d == S_IDLE) || (state_d == S_ACTIVE);
            bus.boot_now       <= (state_d == S_BOOT);
            bus.autoboot_armed <= (state_d == S_IDLE);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                    cnt_d   = 32'(AUTOBOOT_CYCLES);
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            S_IDLE: begin
                // Detach outranks both activity and timeout, so DETACH is entered once.
                if (det_q) begin
                    state_d = S_DETACH;
                    cnt_d   = 32'(DETACH_CYCLES);
                end else if (act_q) begin
                    state_d = S_ACTIVE;
                end else if (cnt_q == '0) begin
                    state_d = S_DETACH;
                    cnt_d   = 32'(DETACH_CYCLES);
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            S_ACTIVE: begin
                if (det_q) begin
                    state_d = S_DETACH;
                    cnt_d   = 32'(DETACH_CYCLES);
                end
            end
            S_DETACH: begin
                if (cnt_q == '0) state_d = S_BOOT;
                else             cnt_d   = cnt_q - 32'd1;
            end
            S_BOOT:  state_d = S_BOOT;
            default: state_d = S_HOLD;
        endcase
    end

    always_comb begin
        mode_d = LED_OFF;
        unique case (state_d)
            S_IDLE:             mode_d = LED_BLINK;
            S_ACTIVE, S_DETACH: mode_d = LED_CYLON;
            default:            mode_d = LED_OFF;
        endcase
    end

    tinydfu_led_pattern #(
        .BLINK_BIT (BLINK_BIT),
        .STEP_BIT  (STEP_BIT)
    ) u_led (
        .clk    (clk),
        .resetn (resetn),
        .mode   (mode_d),
        .led    (bus.led)
    );

endmodule

// File: tb/tb_tinydfu_boot_sequencer.sv
// Directed bench: autoboot timeline from a vector table, then hand-written corner sequences.
module tb_tinydfu_boot_sequencer;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    tinydfu_boot_sequencer_if bus();

    tinydfu_boot_sequencer #(
        .RESET_CYCLES    (10),
        .AUTOBOOT_CYCLES (100),
        .DETACH_CYCLES   (5),
        .BLINK_BIT       (3),
        .STEP_BIT        (2)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [7:0] dfu_state;
        logic       core_reset;
        logic       pull;
        logic       boot;
        logic       armed;
        logic       chk_led;
        logic [2:0] led;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, exp);
        end
    endtask

    // Cycle k = sampled on the falling edge after the k-th rising edge since release.
    task automatic run_to(input int k);
        while (cyc < k) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic restart();
        @(negedge clk);
        resetn = 1'b0;
        bus.dfu_state  = 8'h02;
        bus.dfu_detach = 1'b0;
        bus.stay_btn   = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        cyc = 0;
    endtask

    task automatic check_outs(input string tag, input logic cr, input logic pu, input logic bn, input logic ar);
        check({tag, ".core_reset"},     32'(bus.core_reset),     32'(cr));
        check({tag, ".usb_pull_en"},    32'(bus.usb_pull_en),    32'(pu));
        check({tag, ".boot_now"},       32'(bus.boot_now),       32'(bn));
        check({tag, ".autoboot_armed"}, 32'(bus.autoboot_armed), 32'(ar));
    endtask

    function automatic logic cylon_step_ok(input logic [2:0] a, input logic [2:0] b);
        case ({a, b})
            {3'b110, 3'b101}, {3'b101, 3'b011},
            {3'b101, 3'b110}, {3'b011, 3'b101}: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    initial begin
        logic [2:0] prev_led;
        int viol, nchg, badchg, seen_hi, seen_lo, blink_bad, blink_tog;

        bus.dfu_state  = 8'h02;
        bus.dfu_detach = 1'b0;
        bus.stay_btn   = 1'b0;

        // cyc, dfu_state, core_reset, pull, boot, armed, chk_led, led
        vecs[0] = '{0,   8'h02, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'b111};
        vecs[1] = '{10,  8'h02, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'b111};
        vecs[2] = '{11,  8'h02, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'b000};
        vecs[3] = '{111, 8'h02, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'b000};
        vecs[4] = '{112, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000};
        vecs[5] = '{117, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000};
        vecs[6] = '{118, 8'h02, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3'b111};
        vecs[7] = '{200, 8'h02, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3'b111};

        // Reset values while resetn is held low.
        repeat (3) @(negedge clk);
        check_outs("rst", 1'b1, 1'b0, 1'b0, 1'b0);
        check("rst.led", 32'(bus.led), 32'(3'b111));

        // Plain autoboot timeline.
        restart();
        for (int i = 0; i < 8; i++) begin
            bus.dfu_state = vecs[i].dfu_state;
            run_to(vecs[i].cyc);
            check_outs($sformatf("auto[%0d]", i), vecs[i].core_reset, vecs[i].pull,
                       vecs[i].boot, vecs[i].armed);
            if (vecs[i].chk_led)
                check($sformatf("auto[%0d].led", i), 32'(bus.led), 32'(vecs[i].led));
        end

        // Activity at cycle 50 cancels autoboot; watch blink then cylon.
        restart();
        blink_bad = 0;
        blink_tog = 0;
        run_to(12);
        prev_led = bus.led;
        while (cyc < 50) begin
            run_to(cyc + 1);
            if (bus.led[2:1] !== 2'b11) blink_bad++;
            if (bus.led !== prev_led) blink_tog++;
            prev_led = bus.led;
        end
        check("blink.upper_off", 32'(blink_bad), 32'd0);
        check("blink.toggles", 32'(blink_tog >= 3), 32'd1);
        bus.dfu_state = 8'h05;
        run_to(51);
        check("act.armed_c51", 32'(bus.autoboot_armed), 32'd1);
        run_to(52);
        check_outs("act.c52", 1'b0, 1'b1, 1'b0, 1'b0);
        viol = 0; nchg = 0; badchg = 0; seen_hi = 0; seen_lo = 0;
        prev_led = bus.led;
        for (int i = 0; i < 10000; i++) begin
            if (i == 8) bus.dfu_state = 8'h02;
            run_to(cyc + 1);
            if (bus.boot_now !== 1'b0 || bus.usb_pull_en !== 1'b1 || bus.autoboot_armed !== 1'b0)
                viol++;
            if (bus.led !== prev_led) begin
                nchg++;
                if (!cylon_step_ok(prev_led, bus.led)) badchg++;
                if (bus.led === 3'b011) seen_hi++;
                if (bus.led === 3'b110) seen_lo++;
            end
            prev_led = bus.led;
        end
        check("act.no_boot_10k", 32'(viol), 32'd0);
        check("act.cylon_order", 32'(badchg), 32'd0);
        check("act.cylon_steps", 32'(nchg >= 6 && seen_hi > 0 && seen_lo > 0), 32'd1);

        // Detach pulse while active: sampled at edge N.
        bus.dfu_detach = 1'b1;
        run_to(cyc + 1);
        bus.dfu_detach = 1'b0;
        check("det.pull_N", 32'(bus.usb_pull_en), 32'd1);
        run_to(cyc + 1);
        check_outs("det.N1", 1'b0, 1'b0, 1'b0, 1'b0);
        run_to(cyc + 5);
        check("det.boot_N6", 32'(bus.boot_now), 32'd0);
        run_to(cyc + 1);
        check_outs("det.N7", 1'b1, 1'b0, 1'b1, 1'b0);
        run_to(cyc + 20);
        check("det.boot_sticky", 32'(bus.boot_now), 32'd1);

        // Async reset in S_BOOT: checked between edges, with clk low.
        #2;
        resetn = 1'b0;
        #1;
        check_outs("areset", 1'b1, 1'b0, 1'b0, 1'b0);
        check("areset.led", 32'(bus.led), 32'(3'b111));
        @(negedge clk);
        resetn = 1'b1;
        cyc = 0;
        run_to(10);
        check("rerun.core_c10", 32'(bus.core_reset), 32'd1);
        run_to(11);
        check_outs("rerun.c11", 1'b0, 1'b1, 1'b0, 1'b1);
        run_to(118);
        check("rerun.boot_c118", 32'(bus.boot_now), 32'd1);

        // Stay button one cycle in IDLE; also a detach during HOLD is ignored.
        restart();
        run_to(3);
        bus.dfu_detach = 1'b1;
        run_to(4);
        bus.dfu_detach = 1'b0;
        run_to(11);
        check_outs("hold_det.c11", 1'b0, 1'b1, 1'b0, 1'b1);
        run_to(30);
        bus.stay_btn = 1'b1;
        run_to(31);
        bus.stay_btn = 1'b0;
        run_to(300);
        check_outs("stay.c300", 1'b0, 1'b1, 1'b0, 1'b0);

        // Detach sampled on the same edge the idle counter reaches 0.
        restart();
        run_to(110);
        bus.dfu_detach = 1'b1;
        run_to(111);
        bus.dfu_detach = 1'b0;
        check("sim.pull_c111", 32'(bus.usb_pull_en), 32'd1);
        run_to(112);
        check_outs("sim.c112", 1'b0, 1'b0, 1'b0, 1'b0);
        run_to(117);
        check("sim.boot_c117", 32'(bus.boot_now), 32'd0);
        run_to(118);
        check_outs("sim.c118", 1'b1, 1'b0, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
